full_add_32_serial: RTL

- Bit-serial 32-bit full adder: computes s = x + y + cin and cout, one bit per clock, LSB first.
- Companion to full_sub_32 in the other direction. Feeding it the subtractor's difference d, subtrahend y and borrow-in bin gives back the minuend: x = d + y + bin (mod 2^WIDTH).
- Used where area matters more than latency. Operands are captured on a start handshake, and the result is published with a one-cycle done pulse.

---
 rtl/full_add_32_serial.sv | 89 ++++++++
 1 files changed

// File: rtl/full_add_32_serial.sv
// Bit-serial adder: s = x + y + cin over WIDTH clocks, LSB first.
// Operands are captured on an accepted start; the result is published with a one-cycle done pulse.
module full_add_32_serial #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] psum;
    logic             c;
    logic [CW-1:0]    cnt;

    logic abit;
    logic bbit;
    logic sbit;
    logic cnext;

    always_comb begin
        abit  = a[cnt];
        bbit  = b[cnt];
        sbit  = abit ^ bbit ^ c;
        cnext = (abit & bbit) | (abit & c) | (bbit & c);
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            a     <= '0;
            b     <= '0;
            psum  <= '0;
            c     <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a     <= x;
                        b     <= y;
                        c     <= cin;
                        psum  <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // Sum bits enter at the MSB; after WIDTH shifts bit 0 sits at the LSB.
                    psum <= {sbit, psum[WIDTH-1:1]};
                    c    <= cnext;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        s     <= {sbit, psum[WIDTH-1:1]};
                        cout  <= cnext;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
